// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle: hazard/redirect/dmem requests in, stage enables, flushes and counters out.
// Purely combinational wiring; the master is the datapath side, the slave is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic              load_use_req;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              dmem_req;
  logic              dmem_ready;

  logic              pc_we;
  logic              pc_sel_redir;
  logic [31:0]       pc_redirect;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_we;
  logic              id_ex_flush;
  logic              ex_mem_we;
  logic              ex_mem_flush;
  logic              mem_wb_we;
  logic              mem_wb_flush;
  logic              mem_wait;
  logic              mem_timeout;
  logic              proto_err;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output load_use_req, redirect_valid, redirect_pc, dmem_req, dmem_ready,
    input  pc_we, pc_sel_redir, pc_redirect,
    input  if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    input  ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush,
    input  mem_wait, mem_timeout, proto_err, stall_cycles, flush_events
  );

  modport slave (
    input  load_use_req, redirect_valid, redirect_pc, dmem_req, dmem_ready,
    output pc_we, pc_sel_redir, pc_redirect,
    output if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    output ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush,
    output mem_wait, mem_timeout, proto_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline control: stage enables/flushes and PC select are combinational (same-edge);
// a data-memory miss freezes the whole pipe in MEM_WAIT until dmem_ready, with sticky timeout/error flags.
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input logic               clk,
  input logic               rstn,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic we;
    logic flush;
  } stage_ctl_t;

  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam stage_ctl_t       ST_ADV     = '{we: 1'b1, flush: 1'b0};
  localparam stage_ctl_t       ST_HOLD    = '{we: 1'b0, flush: 1'b0};
  localparam stage_ctl_t       ST_BUBBLE  = '{we: 1'b0, flush: 1'b1};

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             freeze;
  logic             take_redir;
  logic             pc_we;
  logic             pc_sel_redir;
  stage_ctl_t       if_id, id_ex, ex_mem, mem_wb;
  logic             mem_timeout;
  logic             proto_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // While rstn is low every control falls back to "all stages bubble, PC held".
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    take_redir   = 1'b0;
    pc_we        = 1'b0;
    pc_sel_redir = 1'b0;
    if_id        = ST_BUBBLE;
    id_ex        = ST_BUBBLE;
    ex_mem       = ST_BUBBLE;
    mem_wb       = ST_BUBBLE;

    if (rstn) begin
      unique case (state)
        RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            freeze       = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = 8'd1;
          end else if (bus.redirect_valid && !bus.dmem_req) begin
            // A redirect alongside a memory access is illegal and is dropped.
            take_redir = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.dmem_ready) begin
            freeze       = 1'b1;
            wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase

      if (freeze) begin
        if_id  = ST_HOLD;
        id_ex  = ST_HOLD;
        ex_mem = ST_HOLD;
        mem_wb = ST_BUBBLE;
      end else if (take_redir) begin
        pc_we        = 1'b1;
        pc_sel_redir = 1'b1;
        if_id        = ST_BUBBLE;
        id_ex        = ST_BUBBLE;
        ex_mem       = ST_BUBBLE;
        mem_wb       = ST_ADV;
      end else if (bus.load_use_req) begin
        if_id  = ST_HOLD;
        id_ex  = '{we: 1'b1, flush: 1'b1};
        ex_mem = ST_ADV;
        mem_wb = ST_ADV;
      end else begin
        pc_we  = 1'b1;
        if_id  = ST_ADV;
        id_ex  = ST_ADV;
        ex_mem = ST_ADV;
        mem_wb = ST_ADV;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_timeout  <= 1'b0;
      proto_err    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (freeze && (wait_cnt_nxt >= MAX_WAIT_C)) begin
        mem_timeout <= 1'b1;
      end
      if (bus.redirect_valid && bus.dmem_req) begin
        proto_err <= 1'b1;
      end
      if (!pc_we && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (take_redir && !(&flush_events)) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.pc_sel_redir = pc_sel_redir;
  assign bus.pc_redirect  = pc_sel_redir ? bus.redirect_pc : 32'd0;
  assign bus.if_id_we     = if_id.we;
  assign bus.if_id_flush  = if_id.flush;
  assign bus.id_ex_we     = id_ex.we;
  assign bus.id_ex_flush  = id_ex.flush;
  assign bus.ex_mem_we    = ex_mem.we;
  assign bus.ex_mem_flush = ex_mem.flush;
  assign bus.mem_wb_we    = mem_wb.we;
  assign bus.mem_wb_flush = mem_wb.flush;
  assign bus.mem_wait     = (state == MEM_WAIT);
  assign bus.mem_timeout  = mem_timeout;
  assign bus.proto_err    = proto_err;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_events = flush_events;

endmodule
